hazard_forward_unit: RTL and testbench

//   Parametrised data-hazard unit for the pipelined RISC-V core. Tracks the

---
 rtl/hazard_forward_unit_if.sv | 31 +++
 rtl/hazard_forward_unit.sv | 95 +++++++++
 tb/tb_hazard_forward_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// Decode <-> hazard unit bundle: issue info and sources in, stall and forward selects out.
// The master modport is the decode side and the slave modport is the hazard unit.
interface hazard_forward_unit_if #(
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                      issue_valid;
    logic [ADDR_W-1:0]         issue_rd;
    logic                      issue_wb;
    logic                      issue_load;
    logic [NUM_SRC*ADDR_W-1:0] rs_addr;
    logic [NUM_SRC-1:0]        rs_used;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

    modport master (
        output issue_valid, issue_rd, issue_wb, issue_load,
        output rs_addr, rs_used, flush,
        input  stall, fwd_sel
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wb, issue_load,
        input  rs_addr, rs_used, flush,
        output stall, fwd_sel
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Shift-register scoreboard of in-flight rd: youngest-producer forwarding, load-use stall.
// Define HAZARD_PERF_EN to add the stall_cycles / fwd_events counters.
module hazard_forward_unit #(
    parameter int DEPTH       = 3,
    parameter int NUM_SRC     = 2,
    parameter int ADDR_W      = 5,
    parameter int LOAD_STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    hazard_forward_unit_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] fwd_events
`endif
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    if (DEPTH < LOAD_STAGES + 1) begin : g_depth_chk
        $error("hazard_forward_unit: DEPTH must be >= LOAD_STAGES+1");
    end

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              wb;
        logic              load;
    } slot_t;

    slot_t            slots [1:DEPTH];
    slot_t            ins;
    slot_t            aged;
    logic [SEL_W-1:0] youngest [NUM_SRC];
    logic             load_hit;

    function automatic logic hit(slot_t s, logic [ADDR_W-1:0] a, logic u);
        return u && s.valid && s.wb && (s.rd == a) && (s.rd != '0);
    endfunction

    // Scan oldest to youngest so the youngest matching slot is left in place.
    always_comb begin
        load_hit   = 1'b0;
        hz.fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            youngest[i] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (hit(slots[k], hz.rs_addr[i*ADDR_W +: ADDR_W], hz.rs_used[i]))
                    youngest[i] = SEL_W'(k);
            end
            for (int k = 1; k <= LOAD_STAGES; k++) begin
                if (youngest[i] == SEL_W'(k) && slots[k].load)
                    load_hit = 1'b1;
            end
            hz.fwd_sel[i*SEL_W +: SEL_W] = youngest[i];
        end
    end

    assign hz.stall = hz.issue_valid & ~hz.flush & load_hit;

    always_comb begin
        ins.valid  = hz.issue_valid & ~hz.stall & ~hz.flush;
        ins.rd     = hz.issue_rd;
        ins.wb     = hz.issue_wb;
        ins.load   = hz.issue_load;
        aged       = slots[1];
        aged.valid = slots[1].valid & ~hz.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++)
                slots[k] <= '0;
        end else begin
            slots[1] <= ins;
            slots[2] <= aged;
            for (int k = 3; k <= DEPTH; k++)
                slots[k] <= slots[k-1];
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (hz.stall)
                stall_cycles <= stall_cycles + 32'd1;
            if ((|hz.fwd_sel) && hz.issue_valid && !hz.stall)
                fwd_events <= fwd_events + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector table, async reset sequence,
// then random issue traffic against a queue-based model of in-flight producers.
module tb_hazard_forward_unit;
    localparam int DEPTH = 3;
    localparam int NSRC  = 2;
    localparam int AW    = 5;
    localparam int LS    = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.DEPTH(DEPTH), .NUM_SRC(NSRC), .ADDR_W(AW)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] fwd_events;
`endif

    hazard_forward_unit #(
        .DEPTH(DEPTH), .NUM_SRC(NSRC), .ADDR_W(AW), .LOAD_STAGES(LS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hz)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .fwd_events(fwd_events)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model: one record per cycle of what entered the pipe, newest first.
    typedef struct {
        bit v;
        int rd;
        bit wb;
        bit ld;
    } ent_t;
    ent_t hist[$];
    int   m_stalls = 0;
    int   m_fwds   = 0;

    typedef struct {
        bit       v;
        int       rd;
        bit       wb;
        bit       ld;
        int       r0;
        int       r1;
        bit [1:0] used;
        bit       fl;
        bit       st;
        int       s0;
        int       s1;
    } vec_t;
    vec_t tab[20];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_sel(input int a, input bit u);
        if (!u || a == 0) return 0;
        for (int j = 0; j < hist.size(); j++)
            if (hist[j].v && hist[j].wb && hist[j].rd == a) return j + 1;
        return 0;
    endfunction

    function automatic bit m_stall(input bit v, input bit fl, input int a0, input int a1,
                                   input bit [1:0] u);
        int y0, y1;
        bit ld;
        y0 = m_sel(a0, u[0]);
        y1 = m_sel(a1, u[1]);
        ld = 1'b0;
        if (y0 != 0 && y0 <= LS && hist[y0-1].ld) ld = 1'b1;
        if (y1 != 0 && y1 <= LS && hist[y1-1].ld) ld = 1'b1;
        return v && !fl && ld;
    endfunction

    task automatic m_tick(input bit v, input int rd, input bit wb, input bit ld,
                          input bit st, input bit fl, input bit anyfwd);
        ent_t e;
        if (st) m_stalls++;
        if (anyfwd && v && !st) m_fwds++;
        if (fl && hist.size() > 0) begin
            e = hist[0];
            e.v = 1'b0;
            hist[0] = e;
        end
        e.v  = v && !st && !fl;
        e.rd = rd;
        e.wb = wb;
        e.ld = ld;
        hist.push_front(e);
        if (hist.size() > DEPTH) void'(hist.pop_back());
    endtask

    task automatic drive(input bit v, input int rd, input bit wb, input bit ld,
                         input int r0, input int r1, input bit [1:0] u, input bit fl);
        hz.issue_valid = v;
        hz.issue_rd    = AW'(rd);
        hz.issue_wb    = wb;
        hz.issue_load  = ld;
        hz.rs_addr     = {AW'(r1), AW'(r0)};
        hz.rs_used     = u;
        hz.flush       = fl;
    endtask

    // Called at posedge+1; checks at negedge, advances model on the next posedge.
    task automatic apply(input vec_t t, input bit use_tab, input string tag);
        bit st;
        int s0, s1;
        drive(t.v, t.rd, t.wb, t.ld, t.r0, t.r1, t.used, t.fl);
        st = m_stall(t.v, t.fl, t.r0, t.r1, t.used);
        s0 = m_sel(t.r0, t.used[0]);
        s1 = m_sel(t.r1, t.used[1]);
        if (use_tab) begin
            st = t.st;
            s0 = t.s0;
            s1 = t.s1;
        end
        @(negedge clk);
        chk({tag, ".stall"}, int'(hz.stall), int'(st));
        chk({tag, ".sel0"}, int'(hz.fwd_sel[1:0]), s0);
        chk({tag, ".sel1"}, int'(hz.fwd_sel[3:2]), s1);
        @(posedge clk);
        m_tick(t.v, t.rd, t.wb, t.ld, st, t.fl, (s0 != 0) || (s1 != 0));
        #1;
    endtask

    initial begin
        vec_t r;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);

        //            v rd wb ld r0 r1 used  fl st s0 s1
        tab[0]  = '{1, 5, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[1]  = '{1, 6, 1, 0, 5, 0, 2'b01, 0, 0, 1, 0};
        tab[2]  = '{1, 0, 0, 0, 5, 6, 2'b11, 0, 0, 2, 1};
        tab[3]  = '{1, 0, 1, 0, 5, 6, 2'b11, 0, 0, 3, 2};
        tab[4]  = '{0, 0, 0, 0, 5, 6, 2'b11, 0, 0, 0, 3};
        tab[5]  = '{1, 7, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[6]  = '{1, 8, 1, 0, 0, 7, 2'b10, 0, 1, 0, 1};
        tab[7]  = '{1, 8, 1, 0, 0, 7, 2'b10, 0, 0, 0, 2};
        tab[8]  = '{1, 9, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[9]  = '{1,10, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[10] = '{1, 9, 1, 0, 9, 0, 2'b01, 0, 0, 2, 0};
        tab[11] = '{1, 0, 1, 0, 9, 9, 2'b11, 0, 0, 1, 1};
        tab[12] = '{1,11, 1, 1, 0, 9, 2'b01, 0, 0, 0, 0};
        tab[13] = '{1, 0, 0, 0,11, 0, 2'b00, 0, 0, 0, 0};
        tab[14] = '{1,12, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[15] = '{1,12, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[16] = '{1, 0, 0, 0,12,12, 2'b11, 0, 0, 1, 1};
        tab[17] = '{1,13, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0};
        tab[18] = '{1,14, 1, 0,13, 0, 2'b01, 1, 0, 1, 0};
        tab[19] = '{1, 0, 0, 0,13,14, 2'b11, 0, 0, 0, 0};

        #2;
        chk("reset.stall", int'(hz.stall), 0);
        chk("reset.fwd_sel", int'(hz.fwd_sel), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        m_tick(0, 0, 0, 0, 0, 0, 0);
        #1;

        for (int i = 0; i < 20; i++)
            apply(tab[i], 1'b1, $sformatf("vec%0d", i));

        // Async reset with a load in slot 1 and a dependent source pending.
        r = '{1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0};
        apply(r, 1'b0, "rs_fill1");
        r.rd = 2;
        apply(r, 1'b0, "rs_fill2");
        r.rd = 3;
        r.ld = 1'b1;
        apply(r, 1'b0, "rs_fill3");
        drive(1, 4, 1, 0, 3, 1, 2'b11, 0);
        #1;
        chk("rs_pre.stall", int'(hz.stall), 1);
        chk("rs_pre.sel1", int'(hz.fwd_sel[3:2]), 3);
        rst_n = 1'b0;
        #1;
        chk("rs_async.stall", int'(hz.stall), 0);
        chk("rs_async.fwd_sel", int'(hz.fwd_sel), 0);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        hist.delete();
        m_stalls = 0;
        m_fwds   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_tick(0, 0, 0, 0, 0, 0, 0);
        #1;

        for (int n = 0; n < 400; n++) begin
            r.v    = $urandom_range(0, 3) != 0;
            r.rd   = int'($urandom_range(0, 7));
            r.wb   = $urandom_range(0, 3) != 0;
            r.ld   = $urandom_range(0, 2) == 0;
            r.r0   = int'($urandom_range(0, 7));
            r.r1   = int'($urandom_range(0, 7));
            r.used = 2'($urandom_range(0, 3));
            r.fl   = $urandom_range(0, 9) == 0;
            apply(r, 1'b0, "rand");
        end

`ifdef HAZARD_PERF_EN
        chk("perf.stall_cycles", int'(stall_cycles), m_stalls);
        chk("perf.fwd_events", int'(fwd_events), m_fwds);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
